arbitro_mux16: RTL

- Round-robin arbiter that shares one 16:1 datapath multiplexer (16 sources, 4-bit select) among 16 requesters.
- Produces the registered 4-bit select that drives the mux, plus a one-hot grant back to the requesters.
- Holds a grant until the owner releases it or a hold-limit timeout expires.
- Sits between requesting units (register-read ports, peripheral/sprite engines) and the shared multiplexed bus.

---
 rtl/arbitro_mux16.sv | 121 ++++++++++++
 1 files changed

// File: rtl/arbitro_mux16.sv
// Round-robin arbiter owning the select of a shared 16:1 datapath mux.
// A grant is held until the owner releases it or the hold limit expires.
module arbitro_mux16 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_LAST_I);
  localparam logic             HOLD_EN   = (MAX_HOLD != 0);

  state_t           state_q, state_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sel_q, sel_d;
  logic [15:0]      gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [31:0] req_dbl;
  logic [15:0] req_rot;
  logic [3:0]  win_off;
  logic [3:0]  winner;
  logic        rel_owner;
  logic        rel_hold;

  // Rotating by ptr puts the highest-priority requester at bit 0, so the
  // lowest set bit of the rotated vector is the winner's offset from ptr.
  always_comb begin
    req_dbl = {req, req};
    req_rot = 16'(req_dbl >> ptr_q);
    win_off = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (req_rot[k]) win_off = 4'(k);
    end
    winner = ptr_q + win_off;
  end

  always_comb begin
    rel_owner = done | ~req[sel_q];
    rel_hold  = HOLD_EN && (cnt_q == HOLD_LAST);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          sel_d   = winner;
          gnt_d   = 16'h0001 << winner;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        cnt_d = (cnt_q == HOLD_MAX) ? cnt_q : cnt_q + 1'b1;
        if (rel_owner || rel_hold) begin
          state_d   = IDLE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          ptr_d     = sel_q + 4'd1;
          // A forced release is flagged only when the owner did not let go itself.
          timeout_d = rel_hold & ~rel_owner;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule
